adc_sample_decim: RTL and testbench

Downstream stage of the AD9226 capture block in the voice transmit path. It takes the 12-bit offset-binary ADC word on every enabled clock and converts it to two's complement. It then averages blocks of 2^DECIM_LOG2 samples into one audio-rate sample and buffers the results in a small FIFO. The consumer (encoder/modulator) drains the FIFO through a valid/ready handshake.

---
 rtl/adc_sample_decim.sv | 188 ++++++++++++++++++
 tb/tb_adc_sample_decim.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_decim.sv
// adc_sample_decim: offset-binary ADC word -> two's complement, block average of 2^DECIM_LOG2 samples, 2^FIFO_AW-deep output FIFO.
// Latency: the N-th sample in cycle t gives out_valid in t+2 (t+3 with ADC_DC_BLOCK_EN) when the FIFO was empty.
// Backpressure: valid/ready pop; a word arriving while full with no pop is dropped and sets the sticky overflow flag.
// Optional build macro: ADC_DC_BLOCK_EN inserts a registered decimated-rate DC-removal stage ahead of the FIFO.
module adc_sample_decim #(
   parameter int DECIM_LOG2 = 4,
   parameter int FIFO_AW    = 3
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic [11:0]        sample_in,
   input  logic               sample_en,
   output logic [15:0]        out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow
);

   localparam int ACC_W = 12 + DECIM_LOG2;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);

   // ------------------------------------------------------------------
   // Conversion and block accumulator
   // ------------------------------------------------------------------
   logic signed [11:0]        s_conv;
   logic signed [ACC_W-1:0]   sum_c;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [DECIM_LOG2-1:0]     cnt_q, cnt_d;
   logic signed [11:0]        avg_q, avg_d;
   logic                      avg_valid_q, avg_valid_d;

   // Next-state for the accumulator: add the converted sample, or close the block and emit the floored mean.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      // Flipping the MSB maps offset-binary midscale 0x800 to zero.
      s_conv      = {~sample_in[11], sample_in[10:0]};
      // The accumulator is wide enough for N full-scale samples, so the sum never wraps.
      sum_c       = acc_q + {{DECIM_LOG2{s_conv[11]}}, s_conv};
      if (sample_en) begin
         if (cnt_q == '1) begin
            // Arithmetic shift floors toward -inf; the mean always fits back into 12 bits.
            avg_d       = 12'(sum_c >>> DECIM_LOG2);
            avg_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Accumulator, sample counter and averaged-sample register; reset discards any partial block.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
      end
   end

   // ------------------------------------------------------------------
   // FIFO write source: either the raw average or the DC-removed value
   // ------------------------------------------------------------------
   logic        push_vld;
   logic [15:0] push_dat;

`ifdef ADC_DC_BLOCK_EN
   // dc_acc holds 256x the running DC estimate (12.8 fixed point).
   logic signed [19:0] dc_acc_q, dc_acc_d;
   logic signed [12:0] dc_y_q, dc_y_d;
   logic signed [12:0] dc_y_c;
   logic signed [11:0] dc_int;
   logic               dc_vld_q, dc_vld_d;

   // One-pole DC tracker: subtract the integer part of the estimate, then fold the residual back in.
   always_comb begin
      dc_acc_d = dc_acc_q;
      dc_y_d   = dc_y_q;
      dc_vld_d = avg_valid_q;
      // Upper 12 bits equal dc_acc >>> 8 (floor of the estimate).
      dc_int   = dc_acc_q[19:8];
      dc_y_c   = {avg_q[11], avg_q} - {dc_int[11], dc_int};
      if (avg_valid_q) begin
         dc_y_d   = dc_y_c;
         dc_acc_d = dc_acc_q + {{7{dc_y_c[12]}}, dc_y_c};
      end
   end

   // DC stage registers, updated only at the decimated rate.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         dc_acc_q <= '0;
         dc_y_q   <= '0;
         dc_vld_q <= 1'b0;
      end else begin
         dc_acc_q <= dc_acc_d;
         dc_y_q   <= dc_y_d;
         dc_vld_q <= dc_vld_d;
      end
   end

   // Sign-extend the 13-bit residual into the FIFO word.
   always_comb begin
      push_vld = dc_vld_q;
      push_dat = {{3{dc_y_q[12]}}, dc_y_q};
   end
`else
   // Sign-extend the 12-bit average into the FIFO word.
   always_comb begin
      push_vld = avg_valid_q;
      push_dat = {{4{avg_q[11]}}, avg_q};
   end
`endif

   // ------------------------------------------------------------------
   // Show-ahead output FIFO
   // ------------------------------------------------------------------
   logic [15:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               full_c, pop_c, push_ok_c;

   // Pointer/level next-state; a pop in the same cycle frees the slot a full-FIFO push needs.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      full_c    = (level_q == DEPTH_L);
      pop_c     = (level_q != '0) && out_ready;
      push_ok_c = push_vld && (!full_c || pop_c);
      ovf_d     = ovf_q | (push_vld && full_c && !pop_c);
      if (push_ok_c) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok_c && !pop_c) begin
         level_d = level_q + 1'b1;
      end else if (!push_ok_c && pop_c) begin
         level_d = level_q - 1'b1;
      end
   end

   // FIFO state; storage is cleared on reset so the head reads 0x0000 out of reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_dat;
         end
      end
   end

   // Outputs reflect the FIFO head and registered status directly.
   always_comb begin
      out_data   = mem_q[rd_ptr_q];
      out_valid  = (level_q != '0);
      fifo_level = level_q;
      overflow   = ovf_q;
   end

endmodule

// File: tb/tb_adc_sample_decim.sv
// tb_adc_sample_decim: randomized and directed stimulus against a block-mean reference model with a queue scoreboard.
// The driver predicts each decimated word when its block completes; a negedge monitor models FIFO occupancy and checks.
// Bounded run: every phase is a fixed number of cycles, ending in one summary line.
module tb_adc_sample_decim;

   localparam int L = 4;
   localparam int N = 16;
   localparam int D = 8;
`ifdef ADC_DC_BLOCK_EN
   localparam int PUSH_LAT = 2;
`else
   localparam int PUSH_LAT = 1;
`endif

   logic        clk_in    = 1'b0;
   logic        rst_n     = 1'b0;
   logic [11:0] sample_in = '0;
   logic        sample_en = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic [3:0]  fifo_level;
   logic        overflow;

   adc_sample_decim #(.DECIM_LOG2(L), .FIFO_AW(3)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .sample_in  (sample_in),
      .sample_en  (sample_en),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] w;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [15:0] mq[$];
   bit          m_ovf = 1'b0;
   int          blk[$];
   int          dc_m = 0;
   bit          mon_on = 1'b0;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // Reference: mean of the block's signed sample values, floored; optional DC tracker on the mean.
   task automatic block_done();
      int sum;
      int res;
      sum = 0;
      foreach (blk[i]) sum += blk[i];
      res = floor_div(sum, N);
`ifdef ADC_DC_BLOCK_EN
      begin
         int y;
         y    = res - floor_div(dc_m, 256);
         dc_m = dc_m + y;
         res  = y;
      end
`endif
      pend.push_back('{w: 16'(res), due: cyc + PUSH_LAT});
      blk.delete();
   endtask

   task automatic tick(input bit en, input logic [11:0] d, input bit rdy);
      @(posedge clk_in);
      #1;
      sample_en = en;
      sample_in = d;
      out_ready = rdy;
      if (en) begin
         blk.push_back(int'(d) - 2048);
         if (blk.size() == N) block_done();
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) tick(1'b0, 12'h000, rdy);
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #1;
      rst_n     = 1'b0;
      sample_en = 1'b0;
      out_ready = 1'b0;
      blk.delete();
      dc_m = 0;
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic feed_block(input logic [11:0] v, input bit rnd, input bit rdy);
      for (int i = 0; i < N; i++) tick(1'b1, rnd ? 12'($urandom_range(0, 4095)) : v, rdy);
   endtask

   // Monitor: compare DUT against the modelled FIFO, then advance the model by one clock edge.
   initial begin
      forever begin
         @(negedge clk_in);
         if (mon_on) begin
            bit pop_m;
            bit full_m;
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
            if (!rst_n) begin
               mq.delete();
               pend.delete();
               m_ovf = 1'b0;
            end else begin
               full_m = (mq.size() == D);
               pop_m  = (mq.size() != 0) && out_ready;
               if (pop_m) void'(mq.pop_front());
               if (pend.size() != 0 && pend[0].due == cyc) begin
                  pend_t p;
                  p = pend.pop_front();
                  if (!full_m || pop_m) mq.push_back(p.w);
                  else m_ovf = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      @(posedge clk_in);
      #1;
      check("reset_out_data", 32'(out_data), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_fifo_level", 32'(fifo_level), 32'h0);
      check("reset_overflow", 32'(overflow), 32'h0);
      mon_on = 1'b1;
      rst_n  = 1'b1;

      // Midscale, extremes, alternating extremes
      feed_block(12'h800, 1'b0, 1'b1); idle(5, 1'b1);
      feed_block(12'hFFF, 1'b0, 1'b1); idle(5, 1'b1);
      feed_block(12'h000, 1'b0, 1'b1); idle(5, 1'b1);
      for (int i = 0; i < N; i++) tick(1'b1, (i % 2 == 1) ? 12'hFFF : 12'h000, 1'b1);
      idle(5, 1'b1);

      // sample_en every third cycle
      for (int i = 0; i < 3 * N; i++) tick(i % 3 == 0, 12'hC00, 1'b1);
      idle(5, 1'b1);

      // Reset in the middle of a block
      for (int i = 0; i < 10; i++) tick(1'b1, 12'hFFF, 1'b1);
      do_reset();
      feed_block(12'h800, 1'b0, 1'b0);
      idle(PUSH_LAT + 3, 1'b0);
      check("midreset_level", 32'(fifo_level), 32'd1);
      check("midreset_data", 32'(out_data), 32'h0);
      idle(4, 1'b1);

      // Backpressure: nine blocks into an eight-deep FIFO
      for (int b = 0; b < 9; b++) feed_block(12'h000, 1'b1, 1'b0);
      idle(PUSH_LAT + 3, 1'b0);
      check("bp_level_full", 32'(fifo_level), 32'd8);
      check("bp_overflow", 32'(overflow), 32'd1);
      idle(12, 1'b1);
      check("bp_level_drained", 32'(fifo_level), 32'd0);
      check("bp_valid_low", 32'(out_valid), 32'd0);

      // Push and pop in the same cycle while full
      do_reset();
      for (int b = 0; b < 8; b++) feed_block(12'h000, 1'b1, 1'b0);
      idle(PUSH_LAT + 3, 1'b0);
      check("pp_level_before", 32'(fifo_level), 32'd8);
      feed_block(12'h000, 1'b1, 1'b0);
      for (int k = 1; k <= PUSH_LAT; k++) tick(1'b0, 12'h000, k == PUSH_LAT);
      idle(3, 1'b0);
      check("pp_level_after", 32'(fifo_level), 32'd8);
      check("pp_overflow", 32'(overflow), 32'd0);
      idle(12, 1'b1);

      // Constant blocks through the (optional) DC stage
      do_reset();
      for (int b = 0; b < 6; b++) feed_block(12'hC00, 1'b0, 1'b1);
      idle(6, 1'b1);

      // Randomized traffic with alternating drain rates
      for (int i = 0; i < 4000; i++) begin
         bit en;
         bit rdy;
         en  = ($urandom_range(0, 3) != 0);
         rdy = ((i / 500) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
         tick(en, 12'($urandom_range(0, 4095)), rdy);
      end

      idle(30, 1'b1);
      check("final_level", 32'(fifo_level), 32'd0);
      check("final_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
